// File: rtl/serial_link.sv
// -----------------------------------------------------------------------------
// serial_link
//
// Memory-mapped 8-bit serial link. The CPU loads the shift register SB and
// starts a transfer by writing SC with the start bit set. Bits leave MSB
// first on sout while the partner's bits enter at the LSB from sin. The
// serial clock is either generated here (SC[0]=1) or taken from the partner
// on sclk_in (SC[0]=0). One byte completes the transfer, after which the
// start bit clears and irq_serial pulses for one clk.
//
// Ports
//   clk        system clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   addr       CPU bus address (SB = 16'hFF01, SC = 16'hFF02)
//   wr_en      CPU write strobe, one clk per write
//   rd_en      CPU read strobe
//   wdata      CPU write data
//   rdata      CPU read data, combinational
//   sin        serial data from the partner
//   sclk_in    partner serial clock, asynchronous to clk
//   sout       serial data to the partner
//   sclk_out   internally generated serial clock
//   irq_serial one-clk transfer-complete interrupt request
// -----------------------------------------------------------------------------
module serial_link #(
    parameter int HALF_PERIOD = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        sin,
    input  logic        sclk_in,
    output logic        sout,
    output logic        sclk_out,
    output logic        irq_serial
);

    localparam int PHASE_W = (2 * HALF_PERIOD > 1) ? $clog2(2 * HALF_PERIOD) : 1;
    localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * HALF_PERIOD - 1);

    localparam logic [15:0] ADDR_SB = 16'hFF01;
    localparam logic [15:0] ADDR_SC = 16'hFF02;

    typedef enum logic [1:0] {
        IDLE,
        XFER_INT,
        XFER_EXT
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [7:0]           sb;
    logic                 sc_start;
    logic                 sc_clk_sel;
    logic [2:0]           bit_cnt;
    logic [PHASE_W-1:0]   phase;
    logic                 sync1;
    logic                 sync2;
    logic                 sclk_prev;

    logic                 sb_wr;
    logic                 sc_wr;
    logic                 ext_rise;
    logic                 start;
    logic                 abort;
    logic                 do_shift;
    logic                 bit_done;
    logic                 complete;

    assign sb_wr    = wr_en && (addr == ADDR_SB);
    assign sc_wr    = wr_en && (addr == ADDR_SC);
    // Rising edge seen after the two synchronizer flops; sclk_prev holds the
    // previous synchronized level so the edge lasts exactly one clk.
    assign ext_rise = sync2 && !sclk_prev;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and per-clk control strobes. A busy SC write without the
    // start bit is an abort and takes priority over any shift or completion
    // that would otherwise happen on the same clk.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        abort      = 1'b0;
        do_shift   = 1'b0;
        bit_done   = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (sc_wr && wdata[7]) begin
                    start      = 1'b1;
                    next_state = wdata[0] ? XFER_INT : XFER_EXT;
                end
            end
            XFER_INT: begin
                if (sc_wr && !wdata[7]) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    if (phase == HALF_LAST) begin
                        do_shift = 1'b1;
                    end
                    if (phase == PHASE_LAST) begin
                        bit_done = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            complete   = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
            end
            XFER_EXT: begin
                if (sc_wr && !wdata[7]) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (ext_rise) begin
                    do_shift = 1'b1;
                    bit_done = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        complete   = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: shift register, control register bits, counters, external
    // clock synchronizer and the registered interrupt pulse. The synchronizer
    // runs continuously so an external transfer starts with a settled level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb         <= 8'h00;
            sc_start   <= 1'b0;
            sc_clk_sel <= 1'b0;
            bit_cnt    <= 3'd0;
            phase      <= '0;
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            sclk_prev  <= 1'b1;
            irq_serial <= 1'b0;
        end else begin
            sync1      <= sclk_in;
            sync2      <= sync1;
            sclk_prev  <= sync2;
            irq_serial <= complete;

            if (state == IDLE && sb_wr) begin
                sb <= wdata;
            end else if (do_shift) begin
                sb <= {sb[6:0], sin};
            end

            if (state == IDLE && sc_wr) begin
                sc_clk_sel <= wdata[0];
                sc_start   <= wdata[7];
            end else if (abort) begin
                sc_clk_sel <= wdata[0];
                sc_start   <= 1'b0;
            end else if (complete) begin
                sc_start <= 1'b0;
            end

            if (start) begin
                bit_cnt <= 3'd0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Phase only advances while an internal transfer continues.
            if (state == XFER_INT && next_state == XFER_INT) begin
                phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            end else begin
                phase <= '0;
            end
        end
    end

    // Serial outputs idle high; the internal clock is low for the first half
    // of each bit period and high for the second.
    always_comb begin
        sout     = (state == IDLE) ? 1'b1 : sb[7];
        sclk_out = (state == XFER_INT) ? (phase > HALF_LAST) : 1'b1;
    end

    // CPU read mux; unmapped addresses and idle bus read as all ones.
    always_comb begin
        rdata = 8'hFF;
        if (rd_en) begin
            if (addr == ADDR_SB) begin
                rdata = sb;
            end else if (addr == ADDR_SC) begin
                rdata = {sc_start, 6'b111111, sc_clk_sel};
            end
        end
    end

endmodule

// File: tb/tb_serial_link.sv
// -----------------------------------------------------------------------------
// tb_serial_link
//
// Self-checking bench for serial_link. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped when the DUT output
// they describe is sampled.
// -----------------------------------------------------------------------------
module tb_serial_link;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sin;
    logic        sclk_in;
    logic        sout;
    logic        sclk_out;
    logic        irq_serial;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t expQ[$];

    int checks;
    int failures;
    int cycle;
    int irqCount;
    int lastIrqCycle;

    serial_link #(.HALF_PERIOD(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wdata     (wdata),
        .rdata     (rdata),
        .sin       (sin),
        .sclk_in   (sclk_in),
        .sout      (sout),
        .sclk_out  (sclk_out),
        .irq_serial(irq_serial)
    );

    // 10-unit system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far; stable when read on the falling edge.
    initial cycle = 0;
    always @(posedge clk) cycle++;

    // Count every clk that irq_serial is high so pulse width is visible.
    initial begin
        irqCount     = 0;
        lastIrqCycle = -1;
    end
    always @(negedge clk) begin
        if (irq_serial === 1'b1) begin
            irqCount++;
            lastIrqCycle = cycle;
        end
    end

    // Hard stop if something never returns.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        expQ.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] observed);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    // One-clk CPU write; on return cycle equals the edge that took the write.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        addr  = 16'h0000;
    endtask

    task automatic readReg(input logic [15:0] a, input logic en, output logic [7:0] d);
        @(negedge clk);
        addr  = a;
        rd_en = en;
        #1;
        d     = rdata;
        rd_en = 1'b0;
        addr  = 16'h0000;
    endtask

    task automatic waitCycle(input int target);
        while (cycle < target) @(negedge clk);
    endtask

    // Wait for irqCount to move past base, bounded by budget clks.
    task automatic waitIrq(input int base, input int budget, output bit seen);
        int limit;
        limit = cycle + budget;
        seen  = 1'b0;
        while (!seen && cycle < limit) begin
            @(negedge clk);
            #1;
            if (irqCount != base) seen = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] pat;
        int         t0;
        int         base;
        int         riseCycle;
        bit         seen;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        addr     = 16'h0000;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wdata    = 8'h00;
        sin      = 1'b1;
        sclk_in  = 1'b1;

        // Reset values.
        #1;
        checkOutput("rst_sout", sout, 1);
        checkOutput("rst_sclk_out", sclk_out, 1);
        checkOutput("rst_irq", irq_serial, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        readReg(16'hFF01, 1'b1, rd);
        checkOutput("rst_sb", rd, 8'h00);
        readReg(16'hFF02, 1'b1, rd);
        checkOutput("rst_sc", rd, 8'h7E);

        // Internal transfer of A5 with sin held high.
        $display("[TB] internal transfer");
        applyStimulus(16'hFF01, 8'hA5);
        sin  = 1'b1;
        base = irqCount;
        applyStimulus(16'hFF02, 8'h81);
        t0 = cycle;
        pat = 8'hA5;
        for (int k = 7; k >= 0; k--) pushExp($sformatf("int_sout_bit%0d", k), {31'd0, pat[k]});
        pushExp("int_irq_latency", 4096);
        pushExp("int_irq_width", 1);
        pushExp("int_sb_final", 8'hFF);
        pushExp("int_sc_final", 8'h7F);
        for (int k = 0; k < 8; k++) begin
            waitCycle(t0 + 128 + 512 * k);
            popCheck({31'd0, sout});
            checkOutput("int_sclk_low", sclk_out, 0);
            waitCycle(t0 + 384 + 512 * k);
            checkOutput("int_sclk_high", sclk_out, 1);
        end
        waitIrq(base, 4200, seen);
        checkOutput("int_irq_seen", seen, 1);
        popCheck(lastIrqCycle - t0);
        repeat (4) @(negedge clk);
        popCheck(irqCount - base);
        readReg(16'hFF01, 1'b1, rd);
        popCheck(rd);
        readReg(16'hFF02, 1'b1, rd);
        popCheck(rd);
        checkOutput("int_idle_sout", sout, 1);

        // External transfer: 8 partner clocks carrying 96, SB starts at 3C.
        $display("[TB] external transfer");
        applyStimulus(16'hFF01, 8'h3C);
        base = irqCount;
        applyStimulus(16'hFF02, 8'h80);
        pushExp("ext_sb_final", 8'h96);
        pushExp("ext_irq_latency", 3);
        pushExp("ext_irq_width", 1);
        pat = 8'h96;
        riseCycle = 0;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            sin     = pat[i];
            sclk_in = 1'b0;
            repeat (20) @(negedge clk);
            sclk_in = 1'b1;
            riseCycle = cycle;
            if (i == 4) checkOutput("ext_sclk_out", sclk_out, 1);
            if (i == 1) checkOutput("ext_no_early_irq", irqCount - base, 0);
            repeat (19) @(negedge clk);
        end
        readReg(16'hFF01, 1'b1, rd);
        popCheck(rd);
        popCheck(lastIrqCycle - riseCycle);
        popCheck(irqCount - base);
        checkOutput("ext_sclk_idle", sclk_out, 1);

        // Busy writes: SB write and a second start are both ignored.
        $display("[TB] busy writes ignored");
        applyStimulus(16'hFF01, 8'h5A);
        sin  = 1'b1;
        base = irqCount;
        applyStimulus(16'hFF02, 8'h81);
        t0 = cycle;
        pushExp("busy_irq_latency", 4096);
        pushExp("busy_sb_final", 8'hFF);
        waitCycle(t0 + 999);
        applyStimulus(16'hFF01, 8'h00);
        waitCycle(t0 + 1499);
        applyStimulus(16'hFF02, 8'h81);
        waitIrq(base, 4000, seen);
        checkOutput("busy_irq_seen", seen, 1);
        popCheck(lastIrqCycle - t0);
        readReg(16'hFF01, 1'b1, rd);
        popCheck(rd);

        // Abort after three shifted bits.
        $display("[TB] abort");
        applyStimulus(16'hFF01, 8'hA5);
        sin  = 1'b0;
        base = irqCount;
        applyStimulus(16'hFF02, 8'h81);
        t0 = cycle;
        waitCycle(t0 + 1599);
        applyStimulus(16'hFF02, 8'h01);
        pushExp("abort_sb", 8'h28);
        pushExp("abort_sc", 8'h7F);
        pushExp("abort_no_irq", 0);
        #1;
        checkOutput("abort_sout", sout, 1);
        checkOutput("abort_sclk_out", sclk_out, 1);
        readReg(16'hFF01, 1'b1, rd);
        popCheck(rd);
        readReg(16'hFF02, 1'b1, rd);
        popCheck(rd);
        waitCycle(t0 + 5000);
        popCheck(irqCount - base);

        // Reset in the middle of an internal transfer, then a fresh one.
        $display("[TB] reset mid-transfer");
        applyStimulus(16'hFF01, 8'h00);
        sin  = 1'b1;
        base = irqCount;
        applyStimulus(16'hFF02, 8'h81);
        t0 = cycle;
        waitCycle(t0 + 2000);
        checkOutput("pre_rst_sout", sout, 0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_sout", sout, 1);
        checkOutput("mid_rst_sclk_out", sclk_out, 1);
        checkOutput("mid_rst_irq", irq_serial, 0);
        readReg(16'hFF01, 1'b1, rd);
        checkOutput("mid_rst_sb", rd, 8'h00);
        readReg(16'hFF02, 1'b1, rd);
        checkOutput("mid_rst_sc", rd, 8'h7E);
        @(negedge clk);
        rst = 1'b0;
        waitCycle(t0 + 5000);
        checkOutput("rst_no_irq", irqCount - base, 0);
        applyStimulus(16'hFF01, 8'hC3);
        sin  = 1'b0;
        base = irqCount;
        applyStimulus(16'hFF02, 8'h81);
        t0 = cycle;
        pushExp("post_rst_irq_latency", 4096);
        pushExp("post_rst_sb", 8'h00);
        waitIrq(base, 4200, seen);
        checkOutput("post_rst_irq_seen", seen, 1);
        popCheck(lastIrqCycle - t0);
        readReg(16'hFF01, 1'b1, rd);
        popCheck(rd);

        // Read decode and idle SC write without start.
        $display("[TB] read decode");
        readReg(16'hFF00, 1'b1, rd);
        checkOutput("rd_unmapped", rd, 8'hFF);
        readReg(16'hFF01, 1'b0, rd);
        checkOutput("rd_disabled", rd, 8'hFF);
        applyStimulus(16'hFF02, 8'h00);
        readReg(16'hFF02, 1'b1, rd);
        checkOutput("sc_clear_sel", rd, 8'h7E);
        applyStimulus(16'hFF02, 8'h01);
        readReg(16'hFF02, 1'b1, rd);
        checkOutput("sc_set_sel", rd, 8'h7F);
        repeat (300) @(negedge clk);
        checkOutput("no_start_sclk", sclk_out, 1);
        checkOutput("no_start_sout", sout, 1);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_link.md
SERIAL_LINK -- requirements
Module: serial_link

Interface
REQ-001 Parameter: HALF_PERIOD, default 256, clk cycles per serial-clock half period (4.19 MHz / 512 = 8192 Hz).
REQ-002 clk  input  1  system clock (4.19 MHz); all state on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 addr  input  16  CPU bus address; SB = 16'hFF01, SC = 16'hFF02.
REQ-005 wr_en  input  1  CPU write strobe, one clk per write.
REQ-006 rd_en  input  1  CPU read strobe.
REQ-007 wdata  input  8  CPU write data.
REQ-008 rdata  output  8  read data, combinational from addr/rd_en/registers.
REQ-009 sin  input  1  serial data in from link partner.
REQ-010 sclk_in  input  1  external serial clock, asynchronous to clk.
REQ-011 sout  output  1  serial data out.
REQ-012 sclk_out  output  1  internal serial clock driven to partner.
REQ-013 irq_serial  output  1  serial interrupt request, one-clk pulse.

Function
REQ-014 Registers: SB[7:0] shift data; SC start bit SC[7], clock-select bit SC[0] (1 = internal).
REQ-015 Read SB returns SB; read SC returns {SC[7],6'b111111,SC[0]}; rd_en low or any other addr returns 8'hFF.
REQ-016 States: IDLE, XFER_INT, XFER_EXT; 3-bit bit counter; phase counter 0..2*HALF_PERIOD-1.
REQ-017 IDLE: SC write with wdata[7]=1 sets SC[7], latches SC[0], clears bit and phase counters, next state XFER_INT if wdata[0]=1 else XFER_EXT.
REQ-018 IDLE: SB write loads SB; SC write with wdata[7]=0 updates SC[0] only.
REQ-019 sout = SB[7] in XFER states, 1 in IDLE.
REQ-020 XFER_INT: sclk_out low for phase 0..HALF_PERIOD-1, high for HALF_PERIOD..2*HALF_PERIOD-1; sclk_out = 1 in IDLE and XFER_EXT.
REQ-021 XFER_INT: on the clk where phase goes HALF_PERIOD-1 -> HALF_PERIOD (rising sclk), SB <= {SB[6:0], sin}.
REQ-022 XFER_INT: at phase 2*HALF_PERIOD-1, phase wraps to 0, bit counter increments; when bit counter is 7 at that point, transfer completes.
REQ-023 Internal transfer completes exactly 16*HALF_PERIOD clks (4096 default) after the start-write clk.
REQ-024 XFER_EXT: sclk_in passed through 2-flop synchronizer; synchronized rising edge shifts SB <= {SB[6:0], sin}, increments bit counter; 8th rising edge completes transfer.
REQ-025 Completion: SC[7] cleared, irq_serial high for exactly one clk on the next clk, state -> IDLE.
REQ-026 Busy (XFER states): writes to SB ignored; SC write with wdata[7]=1 ignored (no restart); SC write with wdata[7]=0 aborts -> IDLE, SC[7]=0, SB keeps partial shifted value, no irq.
REQ-027 XFER_EXT with no sclk_in edges: waits indefinitely, no timeout.
REQ-028 Reads never alter state.

Reset
REQ-029 On rst assertion, asynchronously: state IDLE, SB=8'h00, SC[7]=0, SC[0]=0, counters 0, synchronizer flops 1, sout=1, sclk_out=1, irq_serial=0.
REQ-030 rst mid-transfer aborts with no irq; first SC start write after deassertion begins a fresh transfer.

Verification
REQ-031 Write SB=8'hA5, SC=8'h81, sin tied 1 -> sout sequence 1,0,1,0,0,1,0,1 (one bit per 512 clks), irq_serial pulse 4096 clks after SC write, SB=8'hFF, read SC=8'h7F.
REQ-032 SB=8'h3C, SC=8'h80, drive 8 sclk_in pulses (period 40 clks) with sin pattern 8'h96 MSB first -> irq after 8th edge + sync latency, SB=8'h96, sclk_out stays 1.
REQ-033 Start internal transfer, write SB=8'h00 after 1000 clks -> write ignored, final SB = sin-shifted value only.
REQ-034 Start internal transfer, write SC=8'h01 after 3 bits -> IDLE, no irq, SC[7]=0, SB shifted by 3.
REQ-035 Assert rst at clk 2000 of internal transfer -> all outputs to reset values immediately, no irq; new start after release completes in 4096 clks.
REQ-036 Read addr 16'hFF00 with rd_en, and any addr with rd_en=0 -> rdata=8'hFF.
